// File: rtl/avalon_master_pkg.sv
// Shared types and constants for the single-outstanding Avalon-MM master.
package avalon_master_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    RD_WAIT,
    RESP
  } avm_state_t;

  localparam logic [31:0] ERR_RDATA = 32'h0;

endpackage

// File: rtl/avalon_master.sv
// Single-outstanding Avalon-MM master: one command in, one bus transaction, one response out,
// with a per-transaction timeout so a silent slave cannot hang the requester.
module avalon_master
  import avalon_master_pkg::*;
#(
  parameter int addr_w  = 32,
  parameter int timeout = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [addr_w-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  input  logic [3:0]        cmd_be,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [addr_w-1:0] address,
  output logic [3:0]        byteenable,
  output logic              write,
  output logic              read,
  output logic [31:0]       writedata,
  input  logic [31:0]       readdata,
  input  logic              waitrequest,
  input  logic              readdatavalid
);

  // A zero timeout still needs a legal counter width even though the counter is never compared.
  localparam int cnt_w = (timeout > 0) ? $clog2(timeout + 1) : 1;

  avm_state_t       state;
  avm_state_t       next_state;
  logic [cnt_w-1:0] cnt;
  logic             at_limit;
  logic             done_ok;
  logic             abort;
  logic             busy;
  logic             accept;

  assign busy     = (state == WR) || (state == RD) || (state == RD_WAIT);
  assign accept   = (state == IDLE) && cmd_valid;
  assign at_limit = (timeout != 0) && (cnt == cnt_w'(timeout));

  // A read is only complete once its data returns, so finishing the address phase
  // on the limit cycle does not rescue it.
  assign done_ok  = ((state == WR) && !waitrequest) ||
                    ((state == RD_WAIT) && readdatavalid);
  assign abort    = busy && at_limit && !done_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          next_state = cmd_we ? WR : RD;
        end
      end
      WR: begin
        if (!waitrequest || at_limit) begin
          next_state = RESP;
        end
      end
      RD: begin
        if (at_limit) begin
          next_state = RESP;
        end else if (!waitrequest) begin
          next_state = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (readdatavalid || at_limit) begin
          next_state = RESP;
        end
      end
      RESP: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_comb begin
    cmd_ready = (state == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= '0;
    end else if (busy) begin
      cnt <= cnt + cnt_w'(1);
    end
  end

  // Bus strobes are registered from the next state so they change exactly on state entry/exit.
  always_ff @(posedge clk) begin
    if (rst) begin
      write     <= 1'b0;
      read      <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      write     <= (next_state == WR);
      read      <= (next_state == RD);
      rsp_valid <= (next_state == RESP);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      address    <= '0;
      writedata  <= '0;
      byteenable <= '0;
    end else if (accept) begin
      address    <= cmd_addr;
      writedata  <= cmd_wdata;
      byteenable <= cmd_be;
    end
  end

  // Response fields only move when a response is produced, so they hold between responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (next_state == RESP) begin
      rsp_err   <= abort;
      rsp_rdata <= ((state == RD_WAIT) && readdatavalid) ? readdata : ERR_RDATA;
    end
  end

endmodule

// File: tb/tb_avalon_master.sv
// Self-checking bench for avalon_master: directed test-plan scenarios plus randomized
// commands checked against a cycle-count reference model.
module tb_avalon_master;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_be;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] address;
  logic [3:0]  byteenable;
  logic        write;
  logic        read;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        waitrequest;
  logic        readdatavalid;

  int          tests_run = 0;
  int          tests_failed = 0;
  logic [31:0] last_rdata = 32'h0;

  avalon_master #(.addr_w(32), .timeout(TMO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_be(cmd_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .address(address), .byteenable(byteenable), .write(write), .read(read),
    .writedata(writedata), .readdata(readdata), .waitrequest(waitrequest),
    .readdatavalid(readdatavalid)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // One command through the bus. stalls = waitrequest cycles, lat = readdatavalid latency after
  // the read is accepted (0 = never). The model counts busy cycles from the cycle after accept.
  task automatic run_txn(input string name, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input int stalls, input int lat, input logic [31:0] rdval);
    int          finish_c;
    int          resp_c;
    int          req_end;
    bit          exp_err;
    logic [31:0] exp_rdata;
    logic [2:0]  exp_bus;
    if (we) finish_c = stalls + 1;
    else if (lat == 0) finish_c = 1 << 20;
    else finish_c = stalls + 1 + lat;
    if (finish_c <= TMO + 1) begin
      resp_c    = finish_c + 1;
      exp_err   = 1'b0;
      exp_rdata = we ? 32'h0 : rdval;
    end else begin
      resp_c    = TMO + 2;
      exp_err   = 1'b1;
      exp_rdata = 32'h0;
    end
    req_end = (stalls + 1 < TMO + 1) ? stalls + 1 : TMO + 1;

    @(negedge clk);
    tests_run++;
    if (cmd_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL %s idle_ready: got %b want 1", name, cmd_ready);
    end
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wdata; cmd_be = be;
    waitrequest = 1'b0; readdatavalid = 1'b0;

    for (int c = 1; c <= resp_c + 1; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_addr  = $urandom;
      cmd_wdata = $urandom;
      exp_bus = {(!we && c <= req_end), (we && c <= req_end), (c == resp_c)};
      tests_run++;
      if ({read, write, rsp_valid} !== exp_bus) begin
        tests_failed++;
        $display("[TB] FAIL %s bus_c%0d: {read,write,rsp_valid} got %b want %b",
                 name, c, {read, write, rsp_valid}, exp_bus);
      end
      if (c <= req_end) begin
        tests_run++;
        if (address !== addr || byteenable !== be || (we && writedata !== wdata)) begin
          tests_failed++;
          $display("[TB] FAIL %s fields_c%0d: addr/be/wdata got %h/%h/%h want %h/%h/%h",
                   name, c, address, byteenable, writedata, addr, be, wdata);
        end
      end
      if (c == resp_c) begin
        tests_run++;
        if (rsp_err !== exp_err || rsp_rdata !== exp_rdata) begin
          tests_failed++;
          $display("[TB] FAIL %s response: err/rdata got %b/%h want %b/%h",
                   name, rsp_err, rsp_rdata, exp_err, exp_rdata);
        end
      end
      if (c == resp_c + 1) begin
        tests_run++;
        if (cmd_ready !== 1'b1 || rsp_rdata !== exp_rdata) begin
          tests_failed++;
          $display("[TB] FAIL %s back_idle: ready/rdata got %b/%h want 1/%h",
                   name, cmd_ready, rsp_rdata, exp_rdata);
        end
      end
      waitrequest   = (c <= stalls);
      readdatavalid = !we && (lat != 0) && (c == stalls + 1 + lat);
      readdata      = readdatavalid ? rdval : $urandom;
    end
    waitrequest   = 1'b0;
    readdatavalid = 1'b0;
    last_rdata    = exp_rdata;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_be = '0;
    readdata = '0; waitrequest = 1'b0; readdatavalid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    tests_run++;
    if ({read, write, rsp_valid, rsp_err} !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL reset_strobes: {read,write,rsp_valid,rsp_err} got %b want 0000",
               {read, write, rsp_valid, rsp_err});
    end
    tests_run++;
    if (address !== 32'h0 || writedata !== 32'h0 || rsp_rdata !== 32'h0 || byteenable !== 4'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_data: addr/wdata/rdata/be got %h/%h/%h/%h want 0",
               address, writedata, rsp_rdata, byteenable);
    end
    tests_run++;
    if (cmd_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_ready: got %b want 1", cmd_ready);
    end
    last_rdata = 32'h0;
  endtask

  task automatic test_stray_rdv();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      readdatavalid = 1'b1;
      readdata      = $urandom;
      tests_run++;
      if (rsp_valid !== 1'b0 || rsp_rdata !== last_rdata || cmd_ready !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL stray_rdv_%0d: valid/rdata/ready got %b/%h/%b want 0/%h/1",
                 i, rsp_valid, rsp_rdata, cmd_ready, last_rdata);
      end
    end
    readdatavalid = 1'b0;
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h40; cmd_be = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0; waitrequest = 1'b1;
    tests_run++;
    if (read !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL midrst_read_up: got %b want 1", read);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; waitrequest = 1'b0;
    tests_run++;
    if (read !== 1'b0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL midrst_after: read/ready/valid/rdata got %b/%b/%b/%h want 0/1/0/0",
               read, cmd_ready, rsp_valid, rsp_rdata);
    end
    last_rdata = 32'h0;
    for (int i = 0; i < TMO + 4; i++) begin
      @(negedge clk);
      tests_run++;
      if (rsp_valid !== 1'b0 || read !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL midrst_quiet_%0d: valid/read got %b/%b want 0/0", i, rsp_valid, read);
      end
    end
    run_txn("midrst_next", 1'b0, 32'h44, 32'h0, 4'hF, 0, 1, 32'hCAFE_F00D);
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      bit we;
      int stalls;
      int lat;
      we     = $urandom_range(0, 1) == 1;
      stalls = $urandom_range(0, 3);
      lat    = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 4);
      run_txn($sformatf("rand%0d", i), we, $urandom, $urandom, 4'($urandom_range(0, 15)),
              stalls, lat, $urandom);
    end
  endtask

  initial begin
    test_reset();
    run_txn("write_nostall", 1'b1, 32'h4, 32'hA5, 4'hF, 0, 1, 32'h0);
    run_txn("read_lat1", 1'b0, 32'h8, 32'h0, 4'hF, 0, 1, 32'h1234_5678);
    run_txn("write_stall5", 1'b1, 32'h10, 32'hDEAD_BEEF, 4'h3, 5, 1, 32'h0);
    run_txn("read_timeout", 1'b0, 32'h20, 32'h0, 4'hF, 0, 0, 32'h5555_AAAA);
    run_txn("read_at_limit", 1'b0, 32'h24, 32'h0, 4'hF, 0, TMO, 32'h0BAD_CAFE);
    run_txn("read_past_limit", 1'b0, 32'h28, 32'h0, 4'hF, 0, TMO + 1, 32'h1111_2222);
    run_txn("write_at_limit", 1'b1, 32'h2C, 32'h77, 4'hC, TMO, 1, 32'h0);
    run_txn("write_timeout", 1'b1, 32'h30, 32'h99, 4'h1, TMO + 5, 1, 32'h0);
    test_stray_rdv();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/avalon_master.md
# avalon_master

Single-outstanding Avalon-MM master that turns simple command requests (read or write, one 32-bit word) into bus transactions. It honours `waitrequest` and pipelined `readdatavalid`, and returns one response per command. It sits between a local controller (test sequencer, DMA-lite, bridge) and the Avalon fabric, driving slaves such as the GPIO peripheral. A timeout counter guarantees forward progress when a slave never answers.

## Interface
Parameters:
- `addr_w`, 32, bus address width
- `timeout`, 255, max wait cycles per transaction; 0 disables timeout

Ports:
- `clk` in 1: clock; all logic on the rising edge
- `rst` in 1: reset, synchronous, active-high
- `cmd_valid` in 1: command present
- `cmd_ready` out 1: command accepted when `cmd_valid && cmd_ready`
- `cmd_we` in 1: 1 = write, 0 = read
- `cmd_addr` in `addr_w`: target address
- `cmd_wdata` in 32: write data
- `cmd_be` in 4: byte enables, passed to `byteenable`
- `rsp_valid` out 1: one-cycle response pulse; no backpressure
- `rsp_rdata` out 32: read data; 0 for writes and for errors
- `rsp_err` out 1: 1 = timeout abort
- `address` out `addr_w`: Avalon address
- `byteenable` out 4: Avalon byte enables
- `write` out 1: Avalon write request
- `read` out 1: Avalon read request
- `writedata` out 32: Avalon write data
- `readdata` in 32: Avalon read data
- `waitrequest` in 1: slave stall; tie to 0 for slaves without it
- `readdatavalid` in 1: read data valid

## Operation
- **States:**
  - IDLE: `cmd_ready` = 1.
  - WR: `write` = 1.
  - RD: `read` = 1.
  - RD_WAIT: `read` = 0, awaiting data.
  - RESP: `rsp_valid` = 1.
- **Accept (IDLE):** on `cmd_valid`, register addr/wdata/be. Next state is WR if `cmd_we`, else RD.
- **WR:** hold `write` and all bus fields stable while `waitrequest` = 1. In the cycle `waitrequest` = 0, go to RESP with `rsp_err` = 0.
- **RD:** hold `read` while `waitrequest` = 1. In the cycle `waitrequest` = 0, go to RD_WAIT.
- **RD_WAIT:** on `readdatavalid`, capture `readdata` into `rsp_rdata` and go to RESP.
- **RESP:** one cycle, then IDLE. `rsp_rdata` and `rsp_err` are valid only while `rsp_valid` = 1 and are held until the next response.
- **Timeout:**
  - Counter is cleared on accept and increments every cycle in WR, RD or RD_WAIT.
  - If it equals `timeout` (nonzero) and completion is not seen that cycle, abort: deassert `read`/`write`, go to RESP with `rsp_err` = 1 and `rsp_rdata` = 0.
  - Completion in the same cycle as the limit wins, so no error is flagged.
- **Stray traffic:** `readdatavalid` outside RD_WAIT is ignored. `readdata` is not captured.
- **Exclusivity:** `read` and `write` are never both 1.
- **Reset:**
  - Output values: state IDLE; `read`, `write`, `rsp_valid`, `rsp_err` = 0; `address`, `writedata`, `rsp_rdata` = 0; `byteenable` = 0; `cmd_ready` = 1 in the first cycle after reset.
  - Reset mid-transaction drops the request at the next edge and emits no response.

## Timing
- All outputs are registered except `cmd_ready`, which is decoded from state.
- **Write, `waitrequest` = 0:** accept at T0, `write` at T1, `rsp_valid` at T2, IDLE at T3. That is 3 cycles per command.
- **Read, slave latency 1:** accept at T0, `read` at T1, `readdatavalid` at T2, `rsp_valid` at T3 with data, IDLE at T4.
- **`waitrequest` stalls:** each stall cycle adds one cycle. **Read latency L:** adds L−1 cycles.
- **Longest busy window:** `timeout`+1 cycles, then RESP.

## Structure
- **Package `avalon_master_pkg`:** state enum `avm_state_t` (IDLE, WR, RD, RD_WAIT, RESP) and the response-data-on-error constant (32'h0).
- **Counter width:** `$clog2(timeout+1)`, computed locally.
- **Sub-modules:** none required. FSM, capture registers and timeout counter are inline, in one module.

## Test plan
- **Write, no stall:** `waitrequest` = 0; write addr 0x4, data 0xA5, be 0xF. Required: `write` = 1 for exactly 1 cycle with `address` = 0x4 and `writedata` = 0xA5; `rsp_valid` 2 cycles after accept with `rsp_err` = 0.
- **Read, latency 1:** slave returns 0x1234_5678 one cycle after `read`. Required: `rsp_rdata` = 0x12345678 and `rsp_err` = 0, 3 cycles after accept.
- **Stalled write:** `waitrequest` = 1 for 5 cycles. Required: `write` and address/data stay stable for 6 cycles; one response.
- **Timeout:** `timeout` = 8; read with `readdatavalid` never asserted. Required: `rsp_err` = 1 and `rsp_rdata` = 0 after 9 busy cycles; `read` already low; back to IDLE.
- **Boundary at the limit:** `readdatavalid` arrives exactly on the limit cycle. Required: `rsp_err` = 0 and data captured. Also: a stray `readdatavalid` in IDLE produces no response.
- **Mid-operation reset:** `rst` asserted during RD. Required: `read` = 0 and `cmd_ready` = 1 after the edge, no `rsp_valid`; the next command completes normally.
